// File: rtl/disp_scan.sv
`default_nettype none
// ============================================================================
// Module   : disp_scan
// Brief    : Scans display slots from a registered responder and streams each
//            slot as 14 ASCII characters ("NAME_:HHHHHHHH") over valid/ready.
// Revision : 1.0 - initial release
// ============================================================================
module disp_scan #(
    parameter int NUM_SLOTS = 44
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        scan_en,
    output logic [5:0]  display_number,
    input  logic        display_valid,
    input  logic [39:0] display_name,
    input  logic [31:0] display_value,
    output logic        ch_valid,
    input  logic        ch_ready,
    output logic [7:0]  ch_code,
    output logic [5:0]  ch_slot,
    output logic [3:0]  ch_pos,
    output logic        frame_done
);

    localparam logic [5:0] c_last_slot = 6'(NUM_SLOTS);
    localparam logic [3:0] c_last_pos  = 4'd13;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_SET      = 2'd1,
        S_WAIT     = 2'd2,
        S_CAP_EMIT = 2'd3
    } state_t;

    state_t      r_state;
    logic [5:0]  r_slot;
    logic        r_snap_valid;
    logic [39:0] r_snap_name;
    logic [31:0] r_snap_value;
    logic [5:0]  w_next_slot;

    assign w_next_slot = (r_slot == c_last_slot) ? 6'd1 : r_slot + 6'd1;

    // Render one column of a slot; empty slots and NUL name bytes show as spaces.
    function automatic logic [7:0] char_at(input logic        v,
                                           input logic [39:0] nm,
                                           input logic [31:0] val,
                                           input logic [3:0]  pos);
        logic [7:0] b;
        logic [3:0] nib;
        int         idx;
        b   = 8'h20;
        nib = 4'h0;
        idx = 0;
        if (v) begin
            if (pos <= 4'd4) begin
                idx = 8 * (4 - int'(pos));
                b   = nm[idx +: 8];
                if (b == 8'h00) begin
                    b = 8'h20;
                end
            end else if (pos == 4'd5) begin
                b = 8'h3A;
            end else if (pos <= c_last_pos) begin
                idx = 4 * (13 - int'(pos));
                nib = val[idx +: 4];
                b   = (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h37 + {4'h0, nib});
            end
        end
        return b;
    endfunction

    always_ff @(posedge clk) begin
        frame_done <= 1'b0;
        if (!resetn) begin
            r_state        <= S_IDLE;
            r_slot         <= 6'd1;
            display_number <= 6'd0;
            ch_valid       <= 1'b0;
            ch_code        <= 8'h00;
            ch_slot        <= 6'd0;
            ch_pos         <= 4'd0;
            r_snap_valid   <= 1'b0;
            r_snap_name    <= 40'd0;
            r_snap_value   <= 32'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (scan_en) begin
                        r_state        <= S_SET;
                        r_slot         <= 6'd1;
                        display_number <= 6'd1;
                    end
                end
                S_SET: begin
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    // Responder output now reflects display_number; freeze it for the whole slot.
                    r_state      <= S_CAP_EMIT;
                    r_snap_valid <= display_valid;
                    r_snap_name  <= display_name;
                    r_snap_value <= display_value;
                    ch_valid     <= 1'b1;
                    ch_pos       <= 4'd0;
                    ch_slot      <= r_slot;
                    ch_code      <= char_at(display_valid, display_name, display_value, 4'd0);
                end
                S_CAP_EMIT: begin
                    if (ch_valid && ch_ready) begin
                        if (ch_pos == c_last_pos) begin
                            ch_valid <= 1'b0;
                            if (r_slot == c_last_slot) begin
                                frame_done <= 1'b1;
                            end
                            if (scan_en) begin
                                r_state        <= S_SET;
                                r_slot         <= w_next_slot;
                                display_number <= w_next_slot;
                            end else begin
                                r_state        <= S_IDLE;
                                display_number <= 6'd0;
                            end
                        end else begin
                            ch_pos  <= ch_pos + 4'd1;
                            ch_code <= char_at(r_snap_valid, r_snap_name, r_snap_value,
                                               ch_pos + 4'd1);
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_disp_scan.sv
`default_nettype none
// ============================================================================
// Module   : tb_disp_scan
// Brief    : Directed self-checking bench for disp_scan with a registered responder.
// Revision : 1.0 - initial release
// ============================================================================
module tb_disp_scan;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        scan_en = 1'b0;
    logic        ch_ready = 1'b1;
    logic [5:0]  display_number;
    logic        display_valid = 1'b0;
    logic [39:0] display_name = 40'd0;
    logic [31:0] display_value = 32'd0;
    logic        ch_valid;
    logic [7:0]  ch_code;
    logic [5:0]  ch_slot;
    logic [3:0]  ch_pos;
    logic        frame_done;

    // Single-slot instance for the NUM_SLOTS=1 boundary
    logic        ready1 = 1'b1;
    logic [5:0]  display_number1;
    logic        display_valid1 = 1'b0;
    logic        ch_valid1;
    logic [7:0]  ch_code1;
    logic [5:0]  ch_slot1;
    logic [3:0]  ch_pos1;
    logic        frame_done1;

    logic        tbl_valid [0:63];
    logic [39:0] tbl_name  [0:63];
    logic [31:0] tbl_value [0:63];
    string       exp_tbl   [0:63];

    int checks = 0;
    int failures = 0;
    int cycle = 0;
    int fd_count = 0;
    int fd1_count = 0;
    int fd1_prev = -1;
    bit chk_fd1 = 1'b0;

    always #5 clk = ~clk;

    disp_scan #(.NUM_SLOTS(44)) dut (
        .clk(clk), .resetn(resetn), .scan_en(scan_en),
        .display_number(display_number), .display_valid(display_valid),
        .display_name(display_name), .display_value(display_value),
        .ch_valid(ch_valid), .ch_ready(ch_ready), .ch_code(ch_code),
        .ch_slot(ch_slot), .ch_pos(ch_pos), .frame_done(frame_done)
    );

    disp_scan #(.NUM_SLOTS(1)) dut1 (
        .clk(clk), .resetn(resetn), .scan_en(scan_en),
        .display_number(display_number1), .display_valid(display_valid1),
        .display_name(40'h4F4E455F31), .display_value(32'h00000001),
        .ch_valid(ch_valid1), .ch_ready(ready1), .ch_code(ch_code1),
        .ch_slot(ch_slot1), .ch_pos(ch_pos1), .frame_done(frame_done1)
    );

    // Registered responder: one cycle from display_number to data
    always @(posedge clk) begin
        display_valid  <= tbl_valid[display_number];
        display_name   <= tbl_name[display_number];
        display_value  <= tbl_value[display_number];
        display_valid1 <= (display_number1 == 6'd1);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cycle);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cycle++;
        if (frame_done) fd_count++;
        if (frame_done1) begin
            fd1_count++;
            if (chk_fd1 && fd1_prev >= 0) check("fd1_gap", 64'(cycle - fd1_prev), 64'd16);
            fd1_prev = cycle;
        end
    endtask

    // Consume one slot of 14 characters, checking every presented character.
    task automatic run_slot(input int slot, input bit rnd, input bit drop7, input bit poke,
                            output int start);
        int    n;
        int    guard;
        string exp;
        n = 0;
        guard = 0;
        start = -1;
        exp = exp_tbl[slot];
        while (n < 14 && guard < 400) begin
            if (ch_valid) begin
                if (start < 0) start = cycle;
                check("code", 64'(ch_code), 64'(exp.getc(n)));
                check("pos", 64'(ch_pos), 64'(n));
                check("slot", 64'(ch_slot), 64'(slot));
                if (drop7 && n == 7) scan_en = 1'b0;
                if (poke && n == 2) begin
                    tbl_value[slot] = 32'hDEADBEEF;
                    tbl_name[slot]  = "XXXXX";
                end
                ch_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
                if (ch_ready) n++;
            end else begin
                ch_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            end
            tick();
            guard++;
        end
        if (n < 14) check("slot_timeout", 64'(n), 64'd14);
        ch_ready = 1'b1;
    endtask

    initial begin
        int start;
        int prev;
        int first;
        int rel;
        int g;
        int bad;

        for (int i = 0; i < 64; i++) begin
            tbl_valid[i] = 1'b0;
            tbl_name[i]  = 40'd0;
            tbl_value[i] = 32'd0;
            exp_tbl[i]   = "              ";
        end
        tbl_valid[1] = 1'b1; tbl_name[1] = "SRC_1"; tbl_value[1] = 32'h0000ABCD;
        exp_tbl[1] = "SRC_1:0000ABCD";
        tbl_valid[2] = 1'b1; tbl_name[2] = {16'h4142, 8'h00, 16'h4344}; tbl_value[2] = 32'hFFFFFFFF;
        exp_tbl[2] = "AB CD:FFFFFFFF";
        tbl_valid[3] = 1'b1; tbl_name[3] = "SLOT3"; tbl_value[3] = 32'h12345678;
        exp_tbl[3] = "SLOT3:12345678";
        tbl_valid[44] = 1'b1; tbl_name[44] = "LAST4"; tbl_value[44] = 32'h9A0F00E1;
        exp_tbl[44] = "LAST4:9A0F00E1";

        // Reset state
        repeat (3) tick();
        check("rst_valid", 64'(ch_valid), 64'd0);
        check("rst_dnum", 64'(display_number), 64'd0);
        check("rst_code", 64'(ch_code), 64'h00);
        check("rst_slot", 64'(ch_slot), 64'd0);
        check("rst_pos", 64'(ch_pos), 64'd0);
        check("rst_fd", 64'(frame_done), 64'd0);
        resetn = 1'b1;
        tick();
        check("idle_valid", 64'(ch_valid), 64'd0);

        // Frame 1: ready held high, first ch_valid on the 3rd edge
        scan_en = 1'b1;
        chk_fd1 = 1'b1;
        rel = cycle;
        tick();
        check("e0_valid", 64'(ch_valid), 64'd0);
        check("e0_dnum", 64'(display_number), 64'd1);
        tick();
        check("e1_valid", 64'(ch_valid), 64'd0);
        tick();
        check("e2_valid", 64'(ch_valid), 64'd1);
        prev = -1;
        first = -1;
        for (int s = 1; s <= 44; s++) begin
            run_slot(s, 1'b0, 1'b0, 1'b0, start);
            if (s == 1) begin
                first = start;
                check("first_valid_edge", 64'(start - rel), 64'd3);
            end else begin
                check("slot_period", 64'(start - prev), 64'd16);
            end
            prev = start;
            check("frame_done_lvl", 64'(frame_done), (s == 44) ? 64'd1 : 64'd0);
            check("next_dnum", 64'(display_number), 64'((s % 44) + 1));
            check("post_valid", 64'(ch_valid), 64'd0);
        end
        check("fd_count", 64'(fd_count), 64'd1);
        tick();
        check("fd_one_cycle", 64'(frame_done), 64'd0);
        check("fd1_seen", 64'(fd1_count >= 40), 64'd1);
        chk_fd1 = 1'b0;

        // Frame 2: random ready, responder change mid-slot, stop during slot 3
        run_slot(1, 1'b1, 1'b0, 1'b0, start);
        check("frame_len", 64'(start - first), 64'd704);
        run_slot(2, 1'b1, 1'b0, 1'b0, start);
        run_slot(3, 1'b1, 1'b1, 1'b1, start);
        check("stop_valid", 64'(ch_valid), 64'd0);
        check("stop_dnum", 64'(display_number), 64'd0);
        check("stop_fd", 64'(frame_done), 64'd0);
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (ch_valid || display_number != 6'd0) bad++;
        end
        check("stays_idle", 64'(bad), 64'd0);

        // Reset while stalled at slot 2 pos 4
        scan_en = 1'b1;
        tick();
        run_slot(1, 1'b0, 1'b0, 1'b0, start);
        g = 0;
        while (!(ch_valid && ch_pos == 4'd4) && g < 100) begin
            tick();
            g++;
        end
        ch_ready = 1'b0;
        check("stall_reach", 64'(ch_pos), 64'd4);
        repeat (2) tick();
        check("stall_pos", 64'(ch_pos), 64'd4);
        check("stall_code", 64'(ch_code), 64'h44);
        check("stall_slot", 64'(ch_slot), 64'd2);
        check("stall_valid", 64'(ch_valid), 64'd1);
        resetn = 1'b0;
        tick();
        check("abort_valid", 64'(ch_valid), 64'd0);
        check("abort_code", 64'(ch_code), 64'h00);
        check("abort_pos", 64'(ch_pos), 64'd0);
        check("abort_dnum", 64'(display_number), 64'd0);
        resetn = 1'b1;
        ch_ready = 1'b1;
        rel = cycle;
        run_slot(1, 1'b0, 1'b0, 1'b0, start);
        check("restart_edge", 64'(start - rel), 64'd3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/disp_scan.md
DISP_SCAN -- requirements
Module: disp_scan

Interface
REQ-001 Parameter: NUM_SLOTS, default 44, number of display slots scanned per frame; legal range 1..63.
REQ-002 Port: clk  input  1  system clock; all logic on rising edge.
REQ-003 Port: resetn  input  1  reset, synchronous, active-low.
REQ-004 Port: scan_en  input  1  level; 1 = scan continuously, 0 = stop at next slot boundary.
REQ-005 Port: display_number  output  6  slot index requested from responder; 0 = none.
REQ-006 Port: display_valid  input  1  responder: slot populated; registered, 1-cycle latency from display_number.
REQ-007 Port: display_name  input  40  responder: 5 ASCII chars, [39:32] leftmost.
REQ-008 Port: display_value  input  32  responder: value for slot.
REQ-009 Port: ch_valid  output  1  character available to sink.
REQ-010 Port: ch_ready  input  1  sink accepts character.
REQ-011 Port: ch_code  output  8  ASCII character.
REQ-012 Port: ch_slot  output  6  slot of current character (1..NUM_SLOTS).
REQ-013 Port: ch_pos  output  4  column within slot, 0..13.
REQ-014 Port: frame_done  output  1  one-cycle pulse after final character of slot NUM_SLOTS.

Function
REQ-015 FSM states: IDLE, SET, WAIT, CAP_EMIT; no other states.
REQ-016 IDLE: display_number=0, ch_valid=0; go to SET with slot=1 at edge where scan_en=1.
REQ-017 SET: display_number driven with current slot, registered; next state WAIT.
REQ-018 WAIT: one cycle for responder register; next state CAP_EMIT.
REQ-019 CAP_EMIT entry edge: snapshot display_valid/name/value into internal registers, assert ch_valid with ch_pos=0.
REQ-020 Snapshot SHALL be held for all 14 characters; responder changes during emission are ignored.
REQ-021 First ch_valid after leaving IDLE: registered at the 3rd rising edge counted from the edge that leaves IDLE.
REQ-022 Handshake: transfer occurs on edge where ch_valid=1 and ch_ready=1; ch_code/ch_slot/ch_pos stable while ch_valid=1 and ch_ready=0.
REQ-023 ch_valid SHALL NOT depend combinationally on ch_ready; with ch_ready held 1, one transfer per cycle.
REQ-024 Character map, valid slot: pos 0..4 = name bytes [39:32]..[7:0], byte 0x00 rendered 0x20; pos 5 = 0x3A ':'; pos 6..13 = value nibbles [31:28]..[3:0] as uppercase hex (0x30-0x39, 0x41-0x46).
REQ-025 Invalid slot (snapshot display_valid=0): all 14 positions emit 0x20.
REQ-026 On transfer at pos 13: ch_valid<=0; if scan_en=1 go to SET with slot+1 (wrap NUM_SLOTS->1); if scan_en=0 go to IDLE, display_number<=0.
REQ-027 Slot period with ch_ready=1: 16 cycles (14 transfers + 2 idle); frame = 16*NUM_SLOTS cycles.
REQ-028 frame_done registered high for exactly one cycle at the edge of pos-13 transfer of slot NUM_SLOTS, regardless of scan_en.
REQ-029 scan_en deassertion mid-slot SHALL NOT truncate the slot; it is sampled only in IDLE and at pos-13 transfer.
REQ-030 NUM_SLOTS=1: every frame rescans slot 1; frame_done pulses each slot.

Reset
REQ-031 resetn=0 at a rising edge: state IDLE, slot=1, display_number=0, ch_valid=0, ch_code=0x00, ch_slot=0, ch_pos=0, frame_done=0, snapshot cleared.
REQ-032 Reset mid-emission SHALL abort immediately; no partial character held; scan restarts from slot 1 after release.

Verification
REQ-033 Reset, scan_en=1, ch_ready=1, slot1 valid name "SRC_1" value 0x0000ABCD -> chars "SRC_1:0000ABCD", ch_slot=1, ch_pos 0..13, first ch_valid at 3rd edge.
REQ-034 Slot 5 display_valid=0 -> 14 x 0x20 with ch_slot=5; full 44-slot frame takes 704 cycles, frame_done pulses once, then display_number=1.
REQ-035 ch_ready toggled pseudo-randomly -> no char lost/duplicated, outputs stable while stalled, value change on responder mid-slot not reflected.
REQ-036 scan_en dropped at slot 3 pos 7 -> slot 3 completes through pos 13, then IDLE, display_number=0, no further ch_valid.
REQ-037 resetn low during slot 2 pos 4 with ch_ready=0 -> ch_valid=0 next edge; after release scan resumes at slot 1 pos 0.
REQ-038 Name byte 0x00 and value 0xFFFFFFFF -> space at that position, "FFFFFFFF" hex digits.
